// File: rtl/adc_spi_sampler.sv
// Periodic SPI ADC sampler: one framed read per SAMPLE_PERIOD, presented as data_out + strobe_out.
// Optional ADC_SPI_SAMPLER_FRAME_CHECK_EN discards frames whose leading bits are not all zero.
module adc_spi_sampler #(
    parameter int unsigned DATA_OUT_LEN  = 10,
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned SAMPLE_PERIOD = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    spi_miso,
    output logic                    spi_sclk,
    output logic                    spi_cs_n,
    output logic [DATA_OUT_LEN-1:0] data_out,
    output logic                    strobe_out
);

    localparam int unsigned FRAME_BITS = DATA_OUT_LEN + 6;
    localparam int unsigned TW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned PW = $clog2(CLK_DIV + 1);
    localparam int unsigned BW = $clog2(FRAME_BITS);
`ifdef ADC_SPI_SAMPLER_FRAME_CHECK_EN
    localparam int unsigned SW = DATA_OUT_LEN + 3;
`else
    // Leading zeros simply fall off the top of a sample-wide register.
    localparam int unsigned SW = DATA_OUT_LEN;
`endif

    localparam logic [TW-1:0] TIMER_LAST   = TW'(SAMPLE_PERIOD - 1);
    localparam logic [PW-1:0] PHASE_LAST   = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST     = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] CAPTURE_LAST = BW'(FRAME_BITS - 4);

    typedef enum logic [2:0] {StIdle, StCsSetup, StShift, StCsHold, StDone} state_e;

    state_e                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [SW-1:0]           shift_q, shift_d;
    logic [DATA_OUT_LEN-1:0] data_q, data_d;
    logic                    strobe_q, strobe_d;
    logic                    sclk_q, sclk_d;
    logic                    cs_n_q, cs_n_d;
    logic                    trigger;
    logic                    phase_end;
    logic                    frame_ok;

    assign trigger   = (timer_q == TIMER_LAST) && enable;
    assign phase_end = (phase_q == PHASE_LAST);
    assign timer_d   = (timer_q == TIMER_LAST) ? '0 : timer_q + TW'(1);

`ifdef ADC_SPI_SAMPLER_FRAME_CHECK_EN
    assign frame_ok = ~|shift_q[SW-1 -: 3];
`else
    assign frame_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d = StCsSetup;
                    phase_d = '0;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                end
            end
            StCsSetup: begin
                if (phase_end) begin
                    state_d = StShift;
                    phase_d = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            StShift: begin
                if (!phase_end) begin
                    phase_d = phase_q + PW'(1);
                end else if (!sclk_q) begin
                    // End of low phase: sample as spi_sclk rises; trailing bits are not kept.
                    phase_d = '0;
                    sclk_d  = 1'b1;
                    if (bit_q <= CAPTURE_LAST) begin
                        shift_d = {shift_q[SW-2:0], spi_miso};
                    end
                end else if (bit_q == BIT_LAST) begin
                    state_d = StCsHold;
                    phase_d = '0;
                end else begin
                    phase_d = '0;
                    bit_d   = bit_q + BW'(1);
                    sclk_d  = 1'b0;
                end
            end
            StCsHold: begin
                if (phase_end) begin
                    state_d = StDone;
                    phase_d = '0;
                    cs_n_d  = 1'b1;
                    if (frame_ok) begin
                        strobe_d = 1'b1;
                        data_d   = shift_q[DATA_OUT_LEN-1:0];
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            phase_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            sclk_q   <= 1'b1;
            cs_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
        end
    end

    assign spi_sclk   = sclk_q;
    assign spi_cs_n   = cs_n_q;
    assign data_out   = data_q;
    assign strobe_out = strobe_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Self-checking bench for adc_spi_sampler with a behavioural SPI ADC and a timing/data model.
// Expectations follow ADC_SPI_SAMPLER_FRAME_CHECK_EN when the build defines it.
module tb_adc_spi_sampler;

    localparam int DL    = 10;
    localparam int CD    = 2;
    localparam int SP    = 100;
    localparam int FRAME = DL + 6;
    localparam int STROBE_OFS = 34 * CD;  // from spi_cs_n fall (T+1) to strobe (T+1+34*CD)

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          spi_miso = 1'b0;
    logic          spi_sclk;
    logic          spi_cs_n;
    logic [DL-1:0] data_out;
    logic          strobe_out;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    logic [FRAME-1:0] next_frame = '0;
    logic [FRAME-1:0] adc_sr = '0;
    logic             adc_cs_prev = 1'b1;
    logic             adc_sclk_prev = 1'b1;
    logic [DL-1:0]    model_data = '0;

    adc_spi_sampler #(
        .DATA_OUT_LEN (DL),
        .CLK_DIV      (CD),
        .SAMPLE_PERIOD(SP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .spi_miso  (spi_miso),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .data_out  (data_out),
        .strobe_out(strobe_out)
    );

    always #5 clk = ~clk;

    // ADC: latches a frame at chip-select fall, presents the next bit MSB-first on each sclk fall.
    always @(posedge clk) begin
        #2;
        if (adc_cs_prev && !spi_cs_n) adc_sr = next_frame;
        if (!spi_cs_n && adc_sclk_prev && !spi_sclk) begin
            spi_miso = adc_sr[FRAME-1];
            adc_sr   = adc_sr << 1;
        end
        adc_cs_prev   = spi_cs_n;
        adc_sclk_prev = spi_sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick;
    endtask

    // Loads the ADC frame and returns whether the sampler should accept it.
    function automatic bit load_frame(input logic [2:0] lead, input logic [DL-1:0] smp,
                                      input logic [2:0] trail);
        next_frame = {lead, smp, trail};
`ifdef ADC_SPI_SAMPLER_FRAME_CHECK_EN
        return (lead == 3'b000);
`else
        return 1'b1;
`endif
    endfunction

    task automatic frame_check(input string tag, input int exp_fall, input bit exp_strobe,
                               input int drop_at, output int stb_cyc);
        int            fall = -1;
        int            rises = 0;
        int            nstb = 0;
        int            consec = 0;
        int            unstable = 0;
        logic          pcs = spi_cs_n;
        logic          psclk = spi_sclk;
        logic          pstb = strobe_out;
        logic [DL-1:0] pdata = data_out;
        stb_cyc = -1;
        while (cyc < exp_fall + STROBE_OFS + 4) begin
            tick;
            if (cyc == drop_at) enable = 1'b0;
            if (pcs && !spi_cs_n && fall < 0) fall = cyc;
            if (!spi_cs_n && !psclk && spi_sclk) rises++;
            if (strobe_out) begin
                nstb++;
                stb_cyc = cyc;
                if (pstb) consec++;
            end else if (data_out !== pdata) begin
                unstable++;
            end
            pcs = spi_cs_n;
            psclk = spi_sclk;
            pstb = strobe_out;
            pdata = data_out;
        end
        check({tag, " cs_fall_cycle"}, fall, exp_fall);
        check({tag, " sclk_rises"}, rises, FRAME);
        check({tag, " strobe_count"}, nstb, exp_strobe ? 1 : 0);
        if (exp_strobe) check({tag, " strobe_cycle"}, stb_cyc, exp_fall + STROBE_OFS);
        check({tag, " strobe_back_to_back"}, consec, 0);
        check({tag, " data_hold"}, unstable, 0);
        check({tag, " data_out"}, data_out, model_data);
        check({tag, " cs_idle_after"}, spi_cs_n, 1'b1);
    endtask

    initial begin
        int   c0, fall, stb, prev_stb, quiet_falls;
        bit   acc;
        logic pcs;
        logic [2:0]    lead;
        logic [DL-1:0] smp;

        reset = 1'b1;
        tick;
        tick;
        check("rst cs_n", spi_cs_n, 1'b1);
        check("rst sclk", spi_sclk, 1'b1);
        check("rst strobe", strobe_out, 1'b0);
        check("rst data", data_out, '0);
        reset  = 1'b0;
        c0     = cyc;
        enable = 1'b1;

        // First frame after reset, sample 0x2A5.
        fall = c0 + SP;
        acc = load_frame(3'b000, 10'h2A5, 3'b101);
        if (acc) model_data = 10'h2A5;
        frame_check("f2a5", fall, acc, -1, stb);

        // Back-to-back extremes, strobes one period apart.
        prev_stb = stb;
        fall += SP;
        acc = load_frame(3'b000, 10'h3FF, 3'b111);
        if (acc) model_data = 10'h3FF;
        frame_check("f3ff", fall, acc, -1, stb);
        check("f3ff spacing", stb - prev_stb, SP);
        prev_stb = stb;
        fall += SP;
        acc = load_frame(3'b000, 10'h001, 3'b000);
        if (acc) model_data = 10'h001;
        frame_check("f001", fall, acc, -1, stb);
        check("f001 spacing", stb - prev_stb, SP);

        // enable dropped at T+10: frame still completes, later triggers suppressed.
        fall += SP;
        acc = load_frame(3'b000, 10'h16B, 3'b010);
        if (acc) model_data = 10'h16B;
        frame_check("fdrop", fall, acc, fall + 9, stb);
        quiet_falls = 0;
        pcs = spi_cs_n;
        while (cyc < fall + 250) begin
            tick;
            if (pcs && !spi_cs_n) quiet_falls++;
            pcs = spi_cs_n;
        end
        check("disabled cs_falls", quiet_falls, 0);
        enable = 1'b1;
        fall += 3 * SP;

        // Good frame followed by one with a stray leading bit.
        acc = load_frame(3'b000, 10'h0AA, 3'b011);
        if (acc) model_data = 10'h0AA;
        frame_check("f0aa", fall, acc, -1, stb);
        fall += SP;
        acc = load_frame(3'b010, 10'h155, 3'b000);
        if (acc) model_data = 10'h155;
        frame_check("flead", fall, acc, -1, stb);

        // Randomized frames, occasionally with non-zero leading bits.
        for (int i = 0; i < 6; i++) begin
            lead = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            smp  = DL'($urandom);
            fall += SP;
            acc = load_frame(lead, smp, 3'($urandom));
            if (acc) model_data = smp;
            frame_check("frand", fall, acc, -1, stb);
        end

        // Reset at T+30 aborts the frame in flight.
        fall += SP;
        acc = load_frame(3'b000, 10'h2C3, 3'b001);
        tick_until(fall + 28);
        check("pre-reset cs_n", spi_cs_n, 1'b0);
        reset = 1'b1;
        tick;
        check("abort cs_n", spi_cs_n, 1'b1);
        check("abort sclk", spi_sclk, 1'b1);
        check("abort strobe", strobe_out, 1'b0);
        check("abort data", data_out, '0);
        model_data = '0;
        tick;
        reset = 1'b0;
        c0    = cyc;
        fall  = c0 + SP;
        acc = load_frame(3'b000, 10'h200, 3'b110);
        if (acc) model_data = 10'h200;
        frame_check("fpost", fall, acc, -1, stb);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
